multi_lut_engine: RTL and testbench
===================================

Name: multi_lut_engine

Overview:
- Streaming multi-channel lookup engine. Each pixel carries CH_NUM indices; each channel is mapped through its own LUT.
- Every channel LUT is double-buffered: a shadow bank is rewritten at runtime while the active bank serves traffic, and the banks swap atomically at a frame boundary.
- Sits between the pixel source and the display/encoder path. It is the runtime-reloadable, multi-channel successor to the single fixed-content ROM lookup blocks.

Parameters:
- CH_NUM, 3, number of channels (1..4).
- ADDR_WIDTH, 10, index width per channel; LUT depth 2^ADDR_WIDTH (8..12).
- DATA_WIDTH, 8, output width per channel (1..16).
- OUTPUT_REG, 1, 1 adds an output register stage; latency L = 1 + OUTPUT_REG.
- CH_W, derived max(1,clog2(CH_NUM)), width of cfg_ch; not user-set.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input pixel qualifier; no backpressure.
- in_sof  in  1  first pixel of frame; meaningful only with in_valid.
- in_data  in  CH_NUM*ADDR_WIDTH  channel indices; ch0 in the LSBs.
- bypass  in  1  1 = pass indices through instead of looking them up; sampled per pixel.
- out_valid  out  1  output qualifier, in_valid delayed by L.
- out_sof  out  1  in_sof delayed by L.
- out_data  out  CH_NUM*DATA_WIDTH  mapped values; ch0 in the LSBs.
- cfg_we  in  1  shadow-bank write strobe.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_addr  in  ADDR_WIDTH  write index.
- cfg_wdata  in  DATA_WIDTH  write value.
- cfg_swap_req  in  1  single-cycle pulse requesting a bank swap.
- cfg_swap_pend  out  1  swap requested but not yet taken.
- active_bank  out  1  bank currently serving lookups.

Behaviour:
- Reset values: out_valid=0, out_sof=0, out_data=0, cfg_swap_pend=0, active_bank=0. In-flight pipeline valids are flushed. RAM contents are not reset and are undefined until written.
- Pipeline:
  - Stage 1 is the synchronous RAM read at address {bank_sel, index}, with valid, sof and bypass carried alongside.
  - Stage 2 (only when OUTPUT_REG=1) is a plain register.
  - Full throughput of 1 pixel/clk. Gaps in in_valid are preserved exactly.
  - When out_valid=0, out_data holds its last value.
- Bypass: per channel, out = in index resized to DATA_WIDTH. Truncation keeps the LSBs; widening zero-extends the MSBs. Same latency L as a lookup.
- Writes:
  - A write goes to bank ~active_bank of channel cfg_ch in one cycle and is never visible in the active bank.
  - cfg_ch >= CH_NUM: the write is ignored.
  - Writes are allowed at any time, including during traffic.
- Swap FSM, two states:
  - IDLE to PEND on cfg_swap_req. cfg_swap_pend is 1 from the next cycle.
  - PEND to IDLE on an accepted pixel with in_valid&in_sof. That pixel and all later pixels read the new bank (bank_sel = ~active_bank combinationally on that cycle). active_bank toggles and pend clears on the next cycle.
  - cfg_swap_req while in PEND: no effect; swaps never double up.
  - Pixels accepted while in PEND without sof use the old bank.
  - cfg_swap_req and an in_sof pixel in the same cycle: the request is registered first; the swap happens at the next sof, not this one.
  - cfg_we in the same cycle as the swap pixel: the write targets the pre-swap inactive bank, which is the bank becoming active. This is legal, but a same-address read on that cycle returns the old RAM data.
- Reset mid-frame: pending swap dropped; active_bank returns to 0; outputs are 0 from the cycle after rst is sampled.

Decomposition:
- Package lut_pkg: clog2 function, latency constant, channel-slice index helper functions.
- Sub-module lut_dpram: simple dual-port RAM, depth 2^(ADDR_WIDTH+1), 1 write port, 1 synchronous read port, no reset. Instantiated CH_NUM times; the bank bit is the address MSB.
- The top module holds the swap FSM, the pipeline and the bypass mux.

Test Plan (CH_NUM=3, ADDR_WIDTH=10, DATA_WIDTH=8, OUTPUT_REG=1):
- Reset: hold rst 2 cycles with traffic present -> out_valid=0, out_data=0, active_bank=0, cfg_swap_pend=0.
- Load and swap: write bank1 addr 5 with ch0=0xA5, ch1=0x5A, ch2=0x3C; pulse cfg_swap_req; send a non-sof pixel and then an sof pixel, both with index 5 on every channel:
  - non-sof pixel -> output is from bank0 (old contents).
  - sof pixel -> out_data=0x3C5AA5 two cycles later with out_sof=1; active_bank=1 and pend=0 one cycle after the sof pixel.
- Bypass: bypass=1, all indices 0x3FF -> out_data=0xFFFFFF at L=2. Toggle bypass each pixel -> per-pixel correct mix of bypass and lookup outputs.
- Throughput: 1024 back-to-back pixels with index 0..1023 after loading identity&0xFF -> out_valid continuous and in order, out = index&0xFF. A random in_valid gap pattern is reproduced exactly.
- Illegal and overlapping writes: cfg_ch=3 write of 0x77 -> no bank is changed. A second cfg_swap_req during PEND -> exactly one toggle at the next sof.
- Mid-frame reset: assert rst with PEND active and 2 pixels in flight -> no out_valid from the in-flight pixels after reset; pend=0; active_bank=0.

Source files
------------

// File: rtl/lut_pkg.sv
// Shared constants, types and helper functions for the multi-channel LUT engine.
package lut_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // cfg_ch must be at least one bit wide even for a single channel.
  function automatic int ch_w(input int ch_num);
    return (clog2(ch_num) < 1) ? 1 : clog2(ch_num);
  endfunction

  function automatic int latency(input int output_reg);
    return 1 + output_reg;
  endfunction

  function automatic int slice_lsb(input int ch, input int width);
    return ch * width;
  endfunction

  typedef enum logic [0:0] {
    SWAP_IDLE = 1'b0,
    SWAP_PEND = 1'b1
  } swap_state_e;

endpackage

// File: rtl/multi_lut_engine_if.sv
// Pixel stream and configuration bus of the multi-channel LUT engine.
interface multi_lut_engine_if import lut_pkg::*; #(
  parameter int CH_NUM     = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int CH_W       = ch_w(CH_NUM)
);
  logic                         in_valid;
  logic                         in_sof;
  logic [CH_NUM*ADDR_WIDTH-1:0] in_data;
  logic                         bypass;
  logic                         out_valid;
  logic                         out_sof;
  logic [CH_NUM*DATA_WIDTH-1:0] out_data;
  logic                         cfg_we;
  logic [CH_W-1:0]              cfg_ch;
  logic [ADDR_WIDTH-1:0]        cfg_addr;
  logic [DATA_WIDTH-1:0]        cfg_wdata;
  logic                         cfg_swap_req;
  logic                         cfg_swap_pend;
  logic                         active_bank;

  modport master (
    output in_valid, in_sof, in_data, bypass,
    output cfg_we, cfg_ch, cfg_addr, cfg_wdata, cfg_swap_req,
    input  out_valid, out_sof, out_data, cfg_swap_pend, active_bank
  );

  modport slave (
    input  in_valid, in_sof, in_data, bypass,
    input  cfg_we, cfg_ch, cfg_addr, cfg_wdata, cfg_swap_req,
    output out_valid, out_sof, out_data, cfg_swap_pend, active_bank
  );
endinterface

// File: rtl/lut_dpram.sv
// Simple dual-port RAM holding both banks of one channel LUT; bank bit is the address MSB.
module lut_dpram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH:0]   waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH:0]   raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_r [0:(2**(ADDR_WIDTH+1))-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem_r[waddr] <= wdata;
  end

  // Read port; a same-address write in the same cycle returns the old word
  always_ff @(posedge clk) begin
    if (re) rdata <= mem_r[raddr];
  end
endmodule

// File: rtl/multi_lut_engine.sv
// Streaming multi-channel lookup engine with double-buffered, runtime-reloadable LUTs.
module multi_lut_engine import lut_pkg::*; #(
  parameter int CH_NUM     = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int OUTPUT_REG = 1
) (
  input logic               clk,
  input logic               rst,
  multi_lut_engine_if.slave bus
);
  localparam int CH_W = ch_w(CH_NUM);

  swap_state_e                  state_r, state_next_s;
  logic                         swap_take_s;
  logic                         bank_sel_s;
  logic                         active_bank_r;
  logic                         pend_r;
  logic [CH_NUM-1:0]            we_s;
  logic [DATA_WIDTH-1:0]        rd_s [CH_NUM];
  logic                         s1_valid_r, s1_sof_r, s1_bypass_r;
  logic [CH_NUM*ADDR_WIDTH-1:0] s1_idx_r;
  logic [CH_NUM*DATA_WIDTH-1:0] s1_data_s;
  logic                         out_valid_s, out_sof_s;
  logic [CH_NUM*DATA_WIDTH-1:0] out_data_s;

  // Swap FSM next state; the sof pixel that takes the swap already reads the new bank
  always_comb begin
    state_next_s = state_r;
    swap_take_s  = 1'b0;
    case (state_r)
      SWAP_IDLE: begin
        if (bus.cfg_swap_req) state_next_s = SWAP_PEND;
        else                  state_next_s = SWAP_IDLE;
      end
      SWAP_PEND: begin
        if (bus.in_valid && bus.in_sof) begin
          swap_take_s  = 1'b1;
          state_next_s = SWAP_IDLE;
        end else begin
          state_next_s = SWAP_PEND;
        end
      end
      default: state_next_s = SWAP_IDLE;
    endcase
  end

  assign bank_sel_s = swap_take_s ? ~active_bank_r : active_bank_r;

  // Swap FSM state, bank pointer and pending flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= SWAP_IDLE;
      active_bank_r <= 1'b0;
      pend_r        <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      active_bank_r <= bank_sel_s;
      pend_r        <= (state_next_s == SWAP_PEND);
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    assign we_s[c] = bus.cfg_we && (bus.cfg_ch == CH_W'(c));

    lut_dpram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
      .clk   (clk),
      .we    (we_s[c]),
      .waddr ({~active_bank_r, bus.cfg_addr}),
      .wdata (bus.cfg_wdata),
      .re    (bus.in_valid),
      .raddr ({bank_sel_s, bus.in_data[slice_lsb(c, ADDR_WIDTH) +: ADDR_WIDTH]}),
      .rdata (rd_s[c])
    );

    assign s1_data_s[slice_lsb(c, DATA_WIDTH) +: DATA_WIDTH] = s1_bypass_r
      ? DATA_WIDTH'(s1_idx_r[slice_lsb(c, ADDR_WIDTH) +: ADDR_WIDTH])
      : rd_s[c];
  end

  // Stage 1 sideband travelling alongside the RAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_sof_r    <= 1'b0;
      s1_bypass_r <= 1'b0;
      s1_idx_r    <= '0;
    end else begin
      s1_valid_r <= bus.in_valid;
      s1_sof_r   <= bus.in_valid && bus.in_sof;
      if (bus.in_valid) begin
        s1_bypass_r <= bus.bypass;
        s1_idx_r    <= bus.in_data;
      end
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic                         out_valid_r, out_sof_r;
    logic [CH_NUM*DATA_WIDTH-1:0] out_data_r;

    // Output register; data holds across gaps
    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_r <= 1'b0;
        out_sof_r   <= 1'b0;
        out_data_r  <= '0;
      end else begin
        out_valid_r <= s1_valid_r;
        out_sof_r   <= s1_sof_r;
        if (s1_valid_r) out_data_r <= s1_data_s;
      end
    end

    assign out_valid_s = out_valid_r;
    assign out_sof_s   = out_sof_r;
    assign out_data_s  = out_data_r;
  end else begin : g_noreg
    logic loaded_r;

    // Masks the unreset RAM output until the first pixel after reset
    always_ff @(posedge clk) begin
      if (rst)               loaded_r <= 1'b0;
      else if (bus.in_valid) loaded_r <= 1'b1;
      else                   loaded_r <= loaded_r;
    end

    assign out_valid_s = s1_valid_r;
    assign out_sof_s   = s1_sof_r;
    assign out_data_s  = loaded_r ? s1_data_s : '0;
  end

  assign bus.out_valid     = out_valid_s;
  assign bus.out_sof       = out_sof_s;
  assign bus.out_data      = out_data_s;
  assign bus.cfg_swap_pend = pend_r;
  assign bus.active_bank   = active_bank_r;
endmodule

// File: tb/tb_multi_lut_engine.sv
// Directed self-checking bench for multi_lut_engine (3 channels, 10-bit index, 8-bit data, L=2).
module tb_multi_lut_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_lut_engine_if #(.CH_NUM(3), .ADDR_WIDTH(10), .DATA_WIDTH(8)) bus_if ();

  multi_lut_engine #(.CH_NUM(3), .ADDR_WIDTH(10), .DATA_WIDTH(8), .OUTPUT_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  localparam logic [29:0] IDX5 = {10'd5, 10'd5, 10'd5};

  int n_checks = 0;
  int n_pass   = 0;

  // Two-deep delay line of expected outputs, fed with hand-computed values
  logic        cur_v = 1'b0, cur_s = 1'b0;
  logic [23:0] cur_d = 24'h0;
  logic        st1_v = 1'b0, st1_s = 1'b0, st2_v = 1'b0, st2_s = 1'b0;
  logic [23:0] st1_d = 24'h0, st2_d = 24'h0, last_d = 24'h0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    st2_v = st1_v; st2_s = st1_s; st2_d = st1_d;
    st1_v = cur_v; st1_s = cur_s; st1_d = cur_d;
    if (rst) begin
      st1_v = 1'b0; st2_v = 1'b0; st1_s = 1'b0; st2_s = 1'b0; last_d = 24'h0;
    end
    cur_v = 1'b0;
    cur_s = 1'b0;
    check_eq("out_valid", 32'(bus_if.out_valid), 32'(st2_v));
    if (st2_v) begin
      check_eq("out_data", 32'(bus_if.out_data), 32'(st2_d));
      check_eq("out_sof", 32'(bus_if.out_sof), 32'(st2_s));
      last_d = st2_d;
    end else begin
      check_eq("out_hold", 32'(bus_if.out_data), 32'(last_d));
    end
  endtask

  task automatic cyc(input logic v, input logic s, input logic b, input logic [29:0] idx,
                     input logic [23:0] exp);
    bus_if.in_valid = v;
    bus_if.in_sof   = s;
    bus_if.bypass   = b;
    bus_if.in_data  = idx;
    cur_v = v;
    cur_s = s;
    cur_d = exp;
    step();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 30'h0, 24'h0);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [9:0] addr, input logic [7:0] data);
    bus_if.cfg_we    = 1'b1;
    bus_if.cfg_ch    = ch;
    bus_if.cfg_addr  = addr;
    bus_if.cfg_wdata = data;
    idle();
    bus_if.cfg_we = 1'b0;
  endtask

  task automatic swap_pulse();
    bus_if.cfg_swap_req = 1'b1;
    idle();
    bus_if.cfg_swap_req = 1'b0;
  endtask

  task automatic check_bank(input string tag, input logic act, input logic pend);
    check_eq({tag, "_active"}, 32'(bus_if.active_bank), 32'(act));
    check_eq({tag, "_pend"}, 32'(bus_if.cfg_swap_pend), 32'(pend));
  endtask

  initial begin
    bus_if.in_valid = 1'b0; bus_if.in_sof = 1'b0; bus_if.bypass = 1'b0; bus_if.in_data = 30'h0;
    bus_if.cfg_we = 1'b0; bus_if.cfg_ch = 2'd0; bus_if.cfg_addr = 10'd0; bus_if.cfg_wdata = 8'h0;
    bus_if.cfg_swap_req = 1'b0;

    // Reset held two cycles with traffic present
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, IDX5, 24'h0);
    cyc(1'b1, 1'b0, 1'b0, IDX5, 24'h0);
    rst = 1'b0;
    check_eq("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus_if.out_data), 32'd0);
    check_bank("rst", 1'b0, 1'b0);

    // Preload both banks at address 5 so that every lookup below is defined
    wr(2'd0, 10'd5, 8'h0F); wr(2'd1, 10'd5, 8'hF0); wr(2'd2, 10'd5, 8'h55);
    swap_pulse();
    check_bank("preA_req", 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, IDX5, 24'h55F00F);
    check_bank("preA_swap", 1'b1, 1'b0);
    wr(2'd0, 10'd5, 8'h01); wr(2'd1, 10'd5, 8'h02); wr(2'd2, 10'd5, 8'h03);
    swap_pulse();
    cyc(1'b1, 1'b1, 1'b0, IDX5, 24'h030201);
    check_bank("preB_swap", 1'b0, 1'b0);

    // Load bank1 and swap: non-sof pixel still reads bank0
    wr(2'd0, 10'd5, 8'hA5); wr(2'd1, 10'd5, 8'h5A); wr(2'd2, 10'd5, 8'h3C);
    swap_pulse();
    check_bank("load_req", 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, IDX5, 24'h030201);
    check_bank("load_nosof", 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, IDX5, 24'h3C5AA5);
    check_bank("load_swap", 1'b1, 1'b0);
    idle(); idle();

    // Bypass, then toggled per pixel
    cyc(1'b1, 1'b0, 1'b1, {10'h3FF, 10'h3FF, 10'h3FF}, 24'hFFFFFF);
    cyc(1'b1, 1'b0, 1'b0, IDX5, 24'h3C5AA5);
    cyc(1'b1, 1'b0, 1'b1, {10'h123, 10'h0AB, 10'h3C0}, 24'h23ABC0);
    cyc(1'b1, 1'b0, 1'b0, IDX5, 24'h3C5AA5);
    cyc(1'b1, 1'b0, 1'b1, {10'h200, 10'h1FF, 10'h080}, 24'h00FF80);
    idle(); idle();

    // Illegal channel write, then a doubled swap request
    wr(2'd3, 10'd5, 8'h77);
    cyc(1'b1, 1'b0, 1'b0, IDX5, 24'h3C5AA5);
    swap_pulse();
    swap_pulse();
    check_bank("dbl_req", 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, IDX5, 24'h030201);
    check_bank("dbl_swap", 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, IDX5, 24'h030201);
    check_bank("dbl_once", 1'b0, 1'b0);

    // Request coinciding with an sof pixel waits for the following sof
    bus_if.cfg_swap_req = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, IDX5, 24'h030201);
    bus_if.cfg_swap_req = 1'b0;
    check_bank("coinc_req", 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, IDX5, 24'h3C5AA5);
    check_bank("coinc_swap", 1'b1, 1'b0);
    idle(); idle();

    // Identity load into bank0, then 1024 back-to-back pixels
    for (int ch = 0; ch < 3; ch++) begin
      for (int a = 0; a < 1024; a++) wr(2'(ch), 10'(a), 8'(a));
    end
    swap_pulse();
    for (int i = 0; i < 1024; i++) begin
      cyc(1'b1, (i == 0) ? 1'b1 : 1'b0, 1'b0, {10'(i), 10'(i), 10'(i)}, {8'(i), 8'(i), 8'(i)});
    end
    check_bank("thru", 1'b0, 1'b0);

    // Random valid gaps are reproduced exactly
    for (int i = 0; i < 64; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, {10'(i + 300), 10'(i + 200), 10'(i + 100)},
          {8'(i + 300), 8'(i + 200), 8'(i + 100)});
    end
    idle(); idle();

    // Mid-frame reset with a swap pending and pixels in flight
    swap_pulse();
    cyc(1'b1, 1'b1, 1'b0, IDX5, 24'h3C5AA5);
    check_bank("mid_pre", 1'b1, 1'b0);
    swap_pulse();
    check_bank("mid_req", 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, IDX5, 24'h3C5AA5);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, IDX5, 24'h3C5AA5);
    check_eq("mid_out_data", 32'(bus_if.out_data), 32'd0);
    check_bank("mid_rst", 1'b0, 1'b0);
    idle();
    rst = 1'b0;
    idle(); idle(); idle();
    check_bank("mid_after", 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, IDX5, 24'h050505);
    idle(); idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
